bus_hold_arbiter: RTL and testbench
===================================

// Module: bus_hold_arbiter
// PURPOSE
//  Shares the 8088 external bus between the CPU and NUM_REQ bus masters (blitter, DSP, video DMA)
//  via the CPU HOLD/HOLDA handshake. Sits beside the 8088 core: drives its HOLD input, samples its
//  HOLDA output, grants exactly one master at a time (round-robin) and enforces a CPU slot between grants.
// PARAMETERS
//  NUM_REQ          3    number of bus-master requesters (2..8)
//  CPU_SLOT_CYCLES  8    CORE_CLK cycles CPU keeps bus after each release (0 = no slot)
//  MAX_HOLD_CYCLES  256  grant length limit, used only with BUS_ARB_TIMEOUT_EN
//  CNT_W            9    counter width; must hold max(CPU_SLOT_CYCLES, MAX_HOLD_CYCLES)
// PORTS
//  CORE_CLK  in   1                single clock, all logic on posedge
//  RESET     in   1                synchronous, active-high
//  REQ       in   NUM_REQ          per-master level request, held until master done
//  GNT       out  NUM_REQ          one-hot grant; master may drive bus only while its bit high
//  HOLD      out  1                to 8088 HOLD
//  HOLDA     in   1                from 8088 HOLDA (same CORE_CLK domain, no sync)
//  OWNER     out  $clog2(NUM_REQ)  index of current/last granted master
//  BUSY      out  1                high in any state other than IDLE
//  TIMEOUT   out  1                1-cycle pulse on forced revoke (tied 0 without macro)
// BEHAVIOUR
//  - Reset: state IDLE, GNT=0, HOLD=0, OWNER=0, BUSY=0, TIMEOUT=0, rr pointer=0, counters=0;
//    RESET mid-operation drops HOLD/GNT on the next edge regardless of HOLDA.
//  - All outputs registered. FSM: IDLE -> HOLD_REQ -> GRANTED -> RELEASE -> CPU_SLOT -> IDLE.
//  - IDLE: if |REQ, pick winner = first set REQ bit searching upward from (last_owner+1) mod NUM_REQ;
//    latch OWNER, HOLD<=1, go HOLD_REQ. First grant after reset searches from index 0.
//  - HOLD_REQ: wait for HOLDA=1; then GNT[OWNER]<=1 next edge (GNT rises 1 cycle after HOLDA seen).
//    If REQ[OWNER] drops before HOLDA: HOLD stays 1 until HOLDA=1 (no 8088 abort), then go
//    RELEASE with no grant issued.
//  - GRANTED: hold while REQ[OWNER]=1. REQ[OWNER]=0 -> GNT<=0, HOLD<=0, go RELEASE (same edge).
//    Other REQ bits ignored; no preemption.
//  - RELEASE: wait HOLDA=0; then load slot counter with CPU_SLOT_CYCLES, go CPU_SLOT
//    (go IDLE directly if CPU_SLOT_CYCLES=0).
//  - CPU_SLOT: decrement each cycle; at 1 -> IDLE. New REQs wait. Counter never wraps.
//  - HOLDA falling while GRANTED (protocol error): GNT<=0, HOLD<=0, go RELEASE.
//  - Simultaneous REQs: round-robin guarantees each requester granted within NUM_REQ grants.
// CONFIGURATION
//  BUS_ARB_TIMEOUT_EN defined: grant counter cleared on entry to GRANTED, increments each
//    GRANTED cycle; at MAX_HOLD_CYCLES GNT<=0, HOLD<=0, TIMEOUT pulses 1 cycle, go RELEASE;
//    that master is ineligible until it drops REQ at least one cycle.
//  Not defined: grants unlimited, TIMEOUT constant 0, counter logic absent.
// STRUCTURE
//  bus_arb_pkg: state enum (IDLE, HOLD_REQ, GRANTED, RELEASE, CPU_SLOT), state width constant.
//  Sub-module rr_picker: combinational round-robin first-set search (req, ptr -> valid, index).
//  Top module: FSM, slot/grant counters, output registers.
// TESTING
//  1 REQ=001 from IDLE -> HOLD=1 next cycle; HOLDA=1 at t -> GNT=001 at t+1, OWNER=0.
//  2 REQ=111 held, each master drops REQ 4 cycles after grant -> grant order 0,1,2,0; 8-cycle
//    CPU slot (HOLD=0) between grants.
//  3 REQ[1] drops before HOLDA -> GNT never rises; HOLD falls after HOLDA=1; FSM passes RELEASE.
//  4 RESET asserted in GRANTED -> next edge GNT=0, HOLD=0, BUSY=0, OWNER=0.
//  5 CPU_SLOT_CYCLES=0, back-to-back REQ -> IDLE reached the cycle after HOLDA=0, re-HOLD next.
//  6 BUS_ARB_TIMEOUT_EN, MAX_HOLD_CYCLES=16, REQ stuck high -> GNT low after 16 cycles, TIMEOUT
//    1-cycle pulse, same master not re-granted until REQ toggles.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared state encoding for the 8088 HOLD/HOLDA bus arbiter.
// Provides the FSM state width and state constants.
package bus_arb_pkg;

  localparam int STATE_W = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_HOLD_REQ = 3'd1;
  localparam logic [2:0] ST_GRANTED  = 3'd2;
  localparam logic [2:0] ST_RELEASE  = 3'd3;
  localparam logic [2:0] ST_CPU_SLOT = 3'd4;

endpackage

// File: rtl/bus_hold_arbiter_rr_picker.sv
// Round-robin first-set search: scans req upward from ptr, wrapping at N.
// Ports: req (requests), ptr (start index) -> valid (any set), idx (winner).
module bus_hold_arbiter_rr_picker #(
  parameter  int N  = 3,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] j;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(ptr) + k) % N);
      if (!valid && req[j]) begin
        valid = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/bus_hold_arbiter.sv
// Shares the 8088 bus between the CPU and NUM_REQ masters via HOLD/HOLDA,
// one round-robin grant at a time with a CPU slot between grants.
// Ports: CORE_CLK, RESET (sync, high), REQ, GNT, HOLD, HOLDA, OWNER, BUSY,
// TIMEOUT. Optional grant-length limit: define BUS_ARB_TIMEOUT_EN.
module bus_hold_arbiter
  import bus_arb_pkg::*;
#(
  parameter  int NUM_REQ         = 3,
  parameter  int CPU_SLOT_CYCLES = 8,
  parameter  int MAX_HOLD_CYCLES = 256,
  parameter  int CNT_W           = 9,
  localparam int IW              = $clog2(NUM_REQ)
) (
  input  logic               CORE_CLK,
  input  logic               RESET,
  input  logic [NUM_REQ-1:0] REQ,
  output logic [NUM_REQ-1:0] GNT,
  output logic               HOLD,
  input  logic               HOLDA,
  output logic [IW-1:0]      OWNER,
  output logic               BUSY,
  output logic               TIMEOUT
);

  if (NUM_REQ < 2 || NUM_REQ > 8 ||
      CPU_SLOT_CYCLES >= 2**CNT_W ||
      MAX_HOLD_CYCLES >= 2**CNT_W ||
      MAX_HOLD_CYCLES < 1) begin : g_cfg_err
    $error("bus_hold_arbiter: bad parameters");
  end

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               hold_q, hold_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q;

  logic [NUM_REQ-1:0] req_elig;
  logic               pick_vld;
  logic [IW-1:0]      pick_idx;
  logic [IW-1:0]      pick_nxt;
  logic               tmo_hit;

  bus_hold_arbiter_rr_picker #(
    .N (NUM_REQ)
  ) u_pick (
    .req   (req_elig),
    .ptr   (ptr_q),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  assign pick_nxt = (pick_idx == IW'(NUM_REQ - 1)) ?
                    '0 : pick_idx + 1'b1;

`ifdef BUS_ARB_TIMEOUT_EN
  logic [CNT_W-1:0]   gcnt_q;
  logic [NUM_REQ-1:0] inel_q;
  logic               tmo_q;
  logic               tmo_fire;

  assign tmo_hit  = (state_q == ST_GRANTED) &&
                    (gcnt_q == CNT_W'(MAX_HOLD_CYCLES - 1));
  // A plain release on the same edge wins; no pulse then.
  assign tmo_fire = tmo_hit && HOLDA && REQ[owner_q];
  assign req_elig = REQ & ~inel_q;
  assign TIMEOUT  = tmo_q;

  always_ff @(posedge CORE_CLK) begin
    if (RESET) begin
      gcnt_q <= '0;
      inel_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      // Zero outside GRANTED, so every grant starts counting from 0.
      gcnt_q <= (state_q == ST_GRANTED) ? gcnt_q + 1'b1 : '0;
      tmo_q  <= tmo_fire;
      // A revoked master stays blocked until it lets REQ go low.
      inel_q <= (inel_q & REQ) |
                (tmo_fire ? NUM_REQ'(1) << owner_q : '0);
    end
  end
`else
  assign tmo_hit  = 1'b0;
  assign req_elig = REQ;
  assign TIMEOUT  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    hold_d  = hold_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          owner_d = pick_idx;
          ptr_d   = pick_nxt;
          hold_d  = 1'b1;
          state_d = ST_HOLD_REQ;
        end
      end
      ST_HOLD_REQ: begin
        // The 8088 cannot abort HOLD, so wait for HOLDA either way.
        if (HOLDA) begin
          if (REQ[owner_q]) begin
            gnt_d   = NUM_REQ'(1) << owner_q;
            state_d = ST_GRANTED;
          end else begin
            hold_d  = 1'b0;
            state_d = ST_RELEASE;
          end
        end
      end
      ST_GRANTED: begin
        if (!HOLDA || !REQ[owner_q] || tmo_hit) begin
          gnt_d   = '0;
          hold_d  = 1'b0;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!HOLDA) begin
          if (CPU_SLOT_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = CNT_W'(CPU_SLOT_CYCLES);
            state_d = ST_CPU_SLOT;
          end
        end
      end
      ST_CPU_SLOT: begin
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        gnt_d   = '0;
        hold_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CORE_CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      hold_q  <= 1'b0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      hold_q  <= hold_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign GNT   = gnt_q;
  assign HOLD  = hold_q;
  assign OWNER = owner_q;
  assign BUSY  = busy_q;

endmodule

// File: tb/tb_bus_hold_arbiter.sv
// Directed bench for bus_hold_arbiter: slot-8 instance plus a slot-0 one.
// Timeout scenario runs when BUS_ARB_TIMEOUT_EN is defined.
module tb_bus_hold_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req, gnt;
  logic       hold, holda, busy, tmo;
  logic [1:0] owner;
  logic [2:0] req0, gnt0;
  logic       hold0, holda0, busy0, tmo0;
  logic [1:0] owner0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_hold_arbiter #(
    .NUM_REQ(3), .CPU_SLOT_CYCLES(8),
    .MAX_HOLD_CYCLES(16), .CNT_W(9)
  ) dut (
    .CORE_CLK(clk), .RESET(rst), .REQ(req), .GNT(gnt),
    .HOLD(hold), .HOLDA(holda), .OWNER(owner),
    .BUSY(busy), .TIMEOUT(tmo)
  );

  bus_hold_arbiter #(
    .NUM_REQ(3), .CPU_SLOT_CYCLES(0),
    .MAX_HOLD_CYCLES(16), .CNT_W(9)
  ) dut0 (
    .CORE_CLK(clk), .RESET(rst), .REQ(req0), .GNT(gnt0),
    .HOLD(hold0), .HOLDA(holda0), .OWNER(owner0),
    .BUSY(busy0), .TIMEOUT(tmo0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; req = '0; holda = 1'b0;
    req0 = '0; holda0 = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; holda = 1'b0;
    req0 = '0; holda0 = 1'b0;
    tick(); tick();
    checks++;
    if ({gnt, hold, busy, tmo} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outs got=%b exp=000000",
               {gnt, hold, busy, tmo});
    end
    checks++;
    if (owner !== 2'd0) begin
      failures++;
      $display("FAIL reset_owner got=%0d exp=0", owner);
    end
    checks++;
    if ({gnt0, hold0, busy0, tmo0, owner0} !== 8'b0) begin
      failures++;
      $display("FAIL reset_dut0 got=%b exp=0",
               {gnt0, hold0, busy0, tmo0, owner0});
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    apply_reset();
    req = 3'b001;
    tick();
    checks++;
    if ({hold, gnt} !== 4'b1000) begin
      failures++;
      $display("FAIL single_hold got=%b exp=1000", {hold, gnt});
    end
    holda = 1'b1;
    tick();
    checks++;
    if (gnt !== 3'b001 || owner !== 2'd0) begin
      failures++;
      $display("FAIL single_gnt got=%b/%0d exp=001/0", gnt, owner);
    end
    req = 3'b000;
    tick();
    checks++;
    if ({gnt, hold, busy} !== 5'b00001) begin
      failures++;
      $display("FAIL single_rel got=%b exp=00001", {gnt, hold, busy});
    end
    holda = 1'b0;
    tick();
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 7) begin
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL slot_busy7 got=%b exp=1", busy);
        end
      end
      if (i == 8) begin
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("FAIL slot_idle8 got=%b exp=0", busy);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int order [4] = '{0, 1, 2, 0};
    int e;
    logic low;
    apply_reset();
    req = 3'b111;
    tick();
    checks++;
    if (hold !== 1'b1) begin
      failures++;
      $display("FAIL rr_hold0 got=%b exp=1", hold);
    end
    for (int g = 0; g < 4; g++) begin
      e = order[g];
      checks++;
      if (owner !== 2'(e)) begin
        failures++;
        $display("FAIL rr_owner%0d got=%0d exp=%0d", g, owner, e);
      end
      holda = 1'b1;
      tick();
      checks++;
      if (gnt !== 3'(1 << e)) begin
        failures++;
        $display("FAIL rr_gnt%0d got=%b exp=%b", g, gnt, 3'(1 << e));
      end
      tick(); tick(); tick();
      checks++;
      if (gnt !== 3'(1 << e)) begin
        failures++;
        $display("FAIL rr_keep%0d got=%b exp=%b", g, gnt, 3'(1 << e));
      end
      req[e] = 1'b0;
      tick();
      checks++;
      if ({gnt, hold} !== 4'b0) begin
        failures++;
        $display("FAIL rr_drop%0d got=%b exp=0000", g, {gnt, hold});
      end
      holda = 1'b0;
      req[e] = 1'b1;
      tick();
      low = 1'b1;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (hold !== 1'b0) low = 1'b0;
      end
      checks++;
      if (low !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL rr_slot%0d got=%b%b exp=10", g, low, busy);
      end
      tick();
      checks++;
      if (hold !== 1'b1) begin
        failures++;
        $display("FAIL rr_rehold%0d got=%b exp=1", g, hold);
      end
    end
  endtask

  task automatic test_abort();
    logic seen = 1'b0;
    apply_reset();
    req = 3'b010;
    tick();
    checks++;
    if (hold !== 1'b1 || owner !== 2'd1) begin
      failures++;
      $display("FAIL abort_hold got=%b/%0d exp=1/1", hold, owner);
    end
    req = 3'b000;
    tick();
    if (gnt !== 3'b0) seen = 1'b1;
    checks++;
    if (hold !== 1'b1) begin
      failures++;
      $display("FAIL abort_keep got=%b exp=1", hold);
    end
    tick();
    if (gnt !== 3'b0) seen = 1'b1;
    holda = 1'b1;
    tick();
    if (gnt !== 3'b0) seen = 1'b1;
    checks++;
    if ({hold, busy} !== 2'b01) begin
      failures++;
      $display("FAIL abort_rel got=%b exp=01", {hold, busy});
    end
    holda = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (gnt !== 3'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_nognt got=%b%b exp=00", seen, busy);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req = 3'b100;
    tick();
    holda = 1'b1;
    tick();
    checks++;
    if (gnt !== 3'b100 || owner !== 2'd2) begin
      failures++;
      $display("FAIL mid_gnt got=%b/%0d exp=100/2", gnt, owner);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({gnt, hold, busy, owner} !== 7'b0) begin
      failures++;
      $display("FAIL mid_reset got=%b exp=0000000",
               {gnt, hold, busy, owner});
    end
    rst = 1'b0; req = '0; holda = 1'b0;
    tick();
  endtask

  task automatic test_no_slot();
    apply_reset();
    req0 = 3'b001;
    tick();
    holda0 = 1'b1;
    tick();
    checks++;
    if (gnt0 !== 3'b001) begin
      failures++;
      $display("FAIL ns_gnt got=%b exp=001", gnt0);
    end
    req0 = 3'b000;
    tick();
    checks++;
    if ({gnt0, hold0} !== 4'b0) begin
      failures++;
      $display("FAIL ns_drop got=%b exp=0000", {gnt0, hold0});
    end
    req0 = 3'b010;
    holda0 = 1'b0;
    tick();
    checks++;
    if ({busy0, hold0} !== 2'b00) begin
      failures++;
      $display("FAIL ns_idle got=%b exp=00", {busy0, hold0});
    end
    tick();
    checks++;
    if (hold0 !== 1'b1 || owner0 !== 2'd1) begin
      failures++;
      $display("FAIL ns_rehold got=%b/%0d exp=1/1", hold0, owner0);
    end
  endtask

`ifdef BUS_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic ok = 1'b1;
    apply_reset();
    req = 3'b001;
    tick();
    holda = 1'b1;
    tick();
    checks++;
    if (gnt !== 3'b001) begin
      failures++;
      $display("FAIL to_gnt got=%b exp=001", gnt);
    end
    for (int i = 0; i < 15; i++) begin
      tick();
      if (gnt !== 3'b001 || tmo !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL to_early got=%b exp=1", ok);
    end
    tick();
    checks++;
    if ({gnt, hold, tmo} !== 5'b00001) begin
      failures++;
      $display("FAIL to_fire got=%b exp=00001", {gnt, hold, tmo});
    end
    holda = 1'b0;
    tick();
    checks++;
    if (tmo !== 1'b0) begin
      failures++;
      $display("FAIL to_pulse got=%b exp=0", tmo);
    end
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if ({hold, busy} !== 2'b00) begin
      failures++;
      $display("FAIL to_blocked got=%b exp=00", {hold, busy});
    end
    req = 3'b000;
    tick();
    req = 3'b001;
    tick();
    checks++;
    if (hold !== 1'b1 || owner !== 2'd0) begin
      failures++;
      $display("FAIL to_regrant got=%b/%0d exp=1/0", hold, owner);
    end
  endtask
`else
  task automatic test_no_timeout();
    logic ok = 1'b1;
    apply_reset();
    req = 3'b001;
    tick();
    holda = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gnt !== 3'b001 || tmo !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL nto_hold got=%b exp=1", ok);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_abort();
    test_reset_mid();
    test_no_slot();
`ifdef BUS_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
